// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin share of one memory port
// among NUM_REQ requesters, with a WAIT watchdog.
module mem_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_SIZE = 16,
  parameter int DATA_SIZE = 8,
  parameter int TIMEOUT   = 16,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(TIMEOUT) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_rw,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_wdata,
  output logic                           rsp_valid,
  output logic [IW-1:0]                  rsp_id,
  output logic [DATA_SIZE-1:0]           rsp_rdata,
  output logic                           rsp_err,
  output logic                           busy,
  output logic                           mem_start,
  output logic                           mem_rw,
  output logic [ADDR_SIZE-1:0]           mem_addr,
  output logic [DATA_SIZE-1:0]           mem_wdata,
  input  logic [DATA_SIZE-1:0]           mem_rdata,
  input  logic                           mem_ready
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t                 state;
  logic [IW-1:0]          last_grant;
  logic [IW-1:0]          hold_id;
  logic [DATA_SIZE-1:0]   hold_rdata;
  logic                   hold_err;
  logic [CW-1:0]          cnt;

  logic                   win_any;
  logic [IW-1:0]          win_id;
  logic [IW-1:0]          cand;
  logic                   accept;

  function automatic logic [IW-1:0] wrap(
    input logic [IW-1:0] base,
    input int            step
  );
    int s;
    s = (int'(base) + step) % NUM_REQ;
    return IW'(s);
  endfunction

  // Round-robin search starting one past the last grant.
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = wrap(last_grant, k);
      if (!win_any && req_valid[cand]) begin
        win_any = 1'b1;
        win_id  = cand;
      end
    end
  end

  assign accept = (state == IDLE) && win_any && !rst;

  assign req_ready = accept
    ? (NUM_REQ'(1) << win_id)
    : '0;

  // Sequencer: accept, issue, wait for ready or timeout,
  // then present the response one cycle after RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      hold_id    <= '0;
      hold_rdata <= '0;
      hold_err   <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      mem_start  <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      mem_start <= 1'b0;
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state      <= ISSUE;
            busy       <= 1'b1;
            mem_start  <= 1'b1;
            mem_rw     <= req_rw[win_id];
            mem_addr   <= req_addr[win_id*ADDR_SIZE +: ADDR_SIZE];
            mem_wdata  <= req_wdata[win_id*DATA_SIZE +: DATA_SIZE];
            hold_id    <= win_id;
            last_grant <= win_id;
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          if (mem_ready) begin
            hold_rdata <= mem_rw ? '0 : mem_rdata;
            hold_err   <= 1'b0;
            state      <= RESP;
          end else if (cnt == CW'(TIMEOUT - 2)) begin
            hold_rdata <= '0;
            hold_err   <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          busy      <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_id    <= hold_id;
          rsp_rdata <= hold_rdata;
          rsp_err   <= hold_err;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed plus random stimulus,
// checked against a transaction-level reference model.
module tb_mem_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      req_rw;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic              mem_start;
  logic              mem_rw;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic              mem_ready;

  mem_rr_arbiter #(
    .NUM_REQ(N),
    .ADDR_SIZE(AW),
    .DATA_SIZE(DW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rw(req_rw),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .busy(busy),
    .mem_start(mem_start),
    .mem_rw(mem_rw),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int errs = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               tag, got, exp, cyc);
    end
  endtask

  // memory device and reference model state
  logic [7:0] memarr [65536];
  logic [7:0] refmem [65536];
  int         mwait = 0;
  logic [15:0] maddr;
  logic       mrw;
  bit         stray = 0;
  bit         dead = 0;
  int         dly = 2;

  bit         mon_on = 0;
  bit         pending = 0;
  int         tA, tR, t_id, t_dly;
  logic       t_rw, t_dead, t_err;
  logic [15:0] t_addr;
  logic [7:0] t_wdata, t_rdata;
  int         last_g = N - 1;
  int         acc_cnt = 0;
  int         rsp_cnt = 0;
  int         last_lat, last_id;
  logic [7:0] last_rdata;
  logic       last_err;
  int         gq [$];
  logic [N-1:0] exp_ready;
  int         w;
  bit         found;

  // Memory device, response scoreboard and grant predictor.
  always @(negedge clk) begin
    if (mon_on) begin
      mem_ready = 1'b0;
      mem_rdata = 8'($urandom);
      if (mwait > 0) begin
        mwait--;
        if (mwait == 0) begin
          mem_ready = 1'b1;
          if (!mrw) mem_rdata = memarr[maddr];
        end
      end
      if (stray) begin
        mem_ready = 1'b1;
        stray = 0;
      end
      if (mem_start && !t_dead) begin
        if (mem_rw) memarr[mem_addr] = mem_wdata;
        maddr = mem_addr;
        mrw   = mem_rw;
        mwait = t_dly;
      end

      chk("busy", busy, pending && cyc >= tA && cyc < tR);
      chk("mem_start", mem_start, pending && cyc == tA);
      if (pending && cyc == tA) begin
        chk("mem_addr", mem_addr, t_addr);
        chk("mem_rw", mem_rw, t_rw);
        if (t_rw) chk("mem_wdata", mem_wdata, t_wdata);
      end
      chk("rsp_valid", rsp_valid, pending && cyc == tR);
      if (pending && (rsp_valid || cyc >= tR)) begin
        if (rsp_valid) begin
          chk("rsp_id", rsp_id, t_id);
          chk("rsp_rdata", rsp_rdata, t_rdata);
          chk("rsp_err", rsp_err, t_err);
          last_lat   = cyc - tA;
          last_id    = rsp_id;
          last_rdata = rsp_rdata;
          last_err   = rsp_err;
          rsp_cnt++;
        end
        pending = 0;
      end

      exp_ready = '0;
      found = 0;
      w = 0;
      if (!pending && !rst) begin
        for (int k = 1; k <= N; k++) begin
          if (!found && req_valid[(last_g + k) % N]) begin
            found = 1;
            w = (last_g + k) % N;
          end
        end
      end
      if (found) exp_ready[w] = 1'b1;
      chk("req_ready", req_ready, exp_ready);

      if (found) begin
        pending = 1;
        tA      = cyc + 1;
        t_id    = w;
        t_rw    = req_rw[w];
        t_addr  = req_addr[w*AW +: AW];
        t_wdata = req_wdata[w*DW +: DW];
        t_dead  = dead;
        t_dly   = dly;
        t_err   = dead;
        tR      = dead ? tA + TO + 1 : tA + dly + 2;
        t_rdata = (dead || t_rw) ? 8'h00 : refmem[t_addr];
        if (!dead && t_rw) refmem[t_addr] = t_wdata;
        last_g  = w;
        acc_cnt++;
        gq.push_back(w);
      end

      if (rst) begin
        pending = 0;
        last_g  = N - 1;
        mwait   = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(
    input int         id,
    input logic       rw,
    input logic [15:0] a,
    input logic [7:0] d
  );
    req_rw[id] = rw;
    req_addr[id*AW +: AW] = a;
    req_wdata[id*DW +: DW] = d;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (pending && k < 100) begin
      tick();
      k++;
    end
    chk("idle", pending, 0);
  endtask

  task automatic issue(
    input int         id,
    input logic       rw,
    input logic [15:0] a,
    input logic [7:0] d,
    input bit         wait_rsp
  );
    int a0, k;
    a0 = acc_cnt;
    set_req(id, rw, a, d);
    req_valid = '0;
    req_valid[id] = 1'b1;
    k = 0;
    while (acc_cnt == a0 && k < 50) begin
      tick();
      k++;
    end
    chk("accept", acc_cnt - a0, 1);
    req_valid = '0;
    if (wait_rsp) wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, a0, k;
    for (int i = 0; i < 65536; i++) begin
      memarr[i] = 8'h00;
      refmem[i] = 8'h00;
    end
    memarr[16'h0040] = 8'hA5;
    refmem[16'h0040] = 8'hA5;
    rst = 1'b1;
    req_valid = '0;
    req_rw = '0;
    req_addr = '0;
    req_wdata = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    tick();
    tick();
    mon_on = 1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mem_start", mem_start, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    dly = 2;
    issue(2, 1'b0, 16'h0040, 8'h00, 1);
    chk("rd_lat", last_lat, 4);
    chk("rd_id", last_id, 2);
    chk("rd_data", last_rdata, 8'hA5);
    chk("rd_err", last_err, 0);

    issue(0, 1'b1, 16'h1234, 8'h3C, 1);
    chk("wr_id", last_id, 0);
    chk("wr_rdata", last_rdata, 0);
    issue(1, 1'b0, 16'h1234, 8'h00, 1);
    chk("rb_id", last_id, 1);
    chk("rb_data", last_rdata, 8'h3C);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++)
      set_req(i, 1'(i & 1), 16'h1230 + 16'(i), 8'(8'h10 + i));
    gq.delete();
    req_valid = '1;
    k = 0;
    while (gq.size() < 8 && k < 300) begin
      dly = $urandom_range(1, 6);
      tick();
      k++;
    end
    req_valid = '0;
    chk("rr_count", gq.size(), 8);
    for (int i = 0; i < 8 && i < gq.size(); i++)
      chk("rr_order", gq[i], i % N);
    wait_idle();

    dly = 2;
    dead = 1;
    issue(3, 1'b0, 16'h0040, 8'h00, 1);
    dead = 0;
    chk("to_lat", last_lat, TO + 1);
    chk("to_id", last_id, 3);
    chk("to_err", last_err, 1);
    chk("to_rdata", last_rdata, 0);
    issue(3, 1'b0, 16'h0040, 8'h00, 1);
    chk("after_to_err", last_err, 0);
    chk("after_to_data", last_rdata, 8'hA5);

    r0 = rsp_cnt;
    dly = 5;
    issue(1, 1'b0, 16'h0040, 8'h00, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_start", mem_start, 0);
    chk("abort_busy", busy, 0);
    dly = 2;
    set_req(0, 1'b0, 16'h1234, 8'h00);
    set_req(2, 1'b0, 16'h0040, 8'h00);
    a0 = acc_cnt;
    req_valid = 4'b0101;
    k = 0;
    while (acc_cnt == a0 && k < 50) begin
      tick();
      k++;
    end
    req_valid = '0;
    chk("post_rst_accept", acc_cnt - a0, 1);
    if (gq.size() > 0) chk("post_rst_grant", gq[$], 0);
    wait_idle();
    chk("abort_no_rsp", rsp_cnt - r0, 1);

    r0 = rsp_cnt;
    stray = 1;
    tick();
    tick();
    tick();
    chk("stray_rsp", rsp_cnt - r0, 0);
    chk("stray_busy", busy, 0);

    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom_range(0, 1)),
                16'h1230 + 16'($urandom_range(0, 15)),
                8'($urandom));
      req_valid = N'($urandom);
      dly = $urandom_range(1, 6);
      dead = ($urandom_range(0, 9) == 0);
      tick();
    end
    req_valid = '0;
    dead = 0;
    wait_idle();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
